// File: rtl/ps2_mouse_cursor_if.sv
// ----------------------------------------------------------------------------
// ps2_mouse_cursor_if
// Groups the signals between the PS/2 mouse receiver, the cursor block and the
// display logic.
//   master : receiver side, drives the PS/2 clock sample, the acknowledge flag
//            and the three packet bytes; observes the cursor outputs.
//   slave  : cursor block, consumes the packet and drives position/buttons.
// ----------------------------------------------------------------------------
interface ps2_mouse_cursor_if;
    logic       PS2_CLK_in;
    logic       Data_reporting_pass;
    logic [7:0] Status_in;
    logic [7:0] X_Direction;
    logic [7:0] Y_Direction;
    logic [9:0] X_Position;
    logic [9:0] Y_Position;
    logic       Left_button;
    logic       Right_button;
    logic       Middle_button;
    logic       Position_valid;
    logic       Packet_error;

    modport master (
        output PS2_CLK_in, Data_reporting_pass, Status_in, X_Direction, Y_Direction,
        input  X_Position, Y_Position, Left_button, Right_button, Middle_button,
               Position_valid, Packet_error
    );

    modport slave (
        input  PS2_CLK_in, Data_reporting_pass, Status_in, X_Direction, Y_Direction,
        output X_Position, Y_Position, Left_button, Right_button, Middle_button,
               Position_valid, Packet_error
    );
endinterface

// File: rtl/ps2_mouse_cursor.sv
// ----------------------------------------------------------------------------
// ps2_mouse_cursor
// Turns 3-byte PS/2 mouse packets into a clamped cursor position and button
// states. A packet is considered complete when the PS/2 clock line has been
// high for IDLE_CYCLES consecutive samples; the falling edges seen during the
// transfer are counted and only a 33-edge transfer is accepted.
//
// Ports:
//   Clock_100MHz : system clock, rising edge
//   Clear_n      : asynchronous active-low reset
//   bus (slave)  : PS2_CLK_in, Data_reporting_pass, Status_in, X_Direction,
//                  Y_Direction in; X_Position, Y_Position, Left/Right/Middle
//                  buttons, Position_valid, Packet_error out
//
// Optional: define PS2_MOUSE_ACCEL_EN to double deltas whose magnitude exceeds
// ACCEL_THRESH.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// S_IDLE   | no transfer in progress, waiting for a PS/2 clock falling edge
// S_ACTIVE | counting falling edges until the clock line goes idle
// S_CHECK  | one cycle: validate edge count, ack flag and status bit 3
// S_APPLY  | one cycle: new position/buttons visible, Position_valid high
// ----------------------------------------------------------------------------
module ps2_mouse_cursor #(
`ifdef PS2_MOUSE_ACCEL_EN
    parameter int ACCEL_THRESH = 16,
`endif
    parameter int H_MAX       = 639,
    parameter int V_MAX       = 479,
    parameter int X_INIT      = 320,
    parameter int Y_INIT      = 240,
    parameter int IDLE_CYCLES = 10000
) (
    input logic               Clock_100MHz,
    input logic               Clear_n,
    ps2_mouse_cursor_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_CHECK, S_APPLY} state_t;

    localparam logic [13:0] IDLE_TC = 14'(IDLE_CYCLES);
    localparam logic [11:0] X_MAX12 = 12'(H_MAX);
    localparam logic [11:0] Y_MAX12 = 12'(V_MAX);

    state_t      state_q;
    logic        sync1_q, sync2_q, sync3_q;
    logic [5:0]  edge_cnt_q;
    logic [13:0] idle_cnt_q;
    logic        pend_q;
    logic [9:0]  x_q, y_q;
    logic        left_q, right_q, mid_q;
    logic        valid_q, err_q;

    logic        fall;
    logic        idle_done;
    logic        accept;
    logic [11:0] dx_d, dy_d;
    logic [11:0] sum_x, sum_y;
    logic [9:0]  x_d, y_d;

    function automatic logic [9:0] clamp(input logic [11:0] v, input logic [11:0] maxv);
        if (v[11])
            return 10'd0;
        else if (v > maxv)
            return maxv[9:0];
        else
            return v[9:0];
    endfunction

`ifdef PS2_MOUSE_ACCEL_EN
    function automatic logic [11:0] accel(input logic [11:0] d);
        logic [11:0] mag;
        mag = d[11] ? (~d + 12'd1) : d;
        return (mag > 12'(ACCEL_THRESH)) ? {d[10:0], 1'b0} : d;
    endfunction
`endif

    assign fall      = sync3_q & ~sync2_q;
    assign idle_done = (idle_cnt_q == IDLE_TC);
    assign accept    = (edge_cnt_q == 6'd33) && bus.Data_reporting_pass && bus.Status_in[3];

    // Overflow forcing comes first so an overflowed axis never gets accelerated.
    always_comb begin
        dx_d = bus.Status_in[6] ? 12'd0 : {{4{bus.Status_in[4]}}, bus.X_Direction};
        dy_d = bus.Status_in[7] ? 12'd0 : {{4{bus.Status_in[5]}}, bus.Y_Direction};
`ifdef PS2_MOUSE_ACCEL_EN
        dx_d = accel(dx_d);
        dy_d = accel(dy_d);
`endif
        // Screen Y grows downward while mouse Y grows upward.
        sum_x = {2'b00, x_q} + dx_d;
        sum_y = {2'b00, y_q} - dy_d;
        x_d   = clamp(sum_x, X_MAX12);
        y_d   = clamp(sum_y, Y_MAX12);
    end

    always_ff @(posedge Clock_100MHz or negedge Clear_n) begin
        if (!Clear_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
        end else begin
            sync1_q <= bus.PS2_CLK_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    always_ff @(posedge Clock_100MHz or negedge Clear_n) begin
        if (!Clear_n) begin
            state_q    <= S_IDLE;
            edge_cnt_q <= 6'd0;
            idle_cnt_q <= 14'd0;
            pend_q     <= 1'b0;
            x_q        <= 10'(X_INIT);
            y_q        <= 10'(Y_INIT);
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            mid_q      <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;

            if (!sync2_q)
                idle_cnt_q <= 14'd0;
            else if (idle_cnt_q != IDLE_TC)
                idle_cnt_q <= idle_cnt_q + 14'd1;

            case (state_q)
                S_IDLE: begin
                    if (fall) begin
                        state_q    <= S_ACTIVE;
                        edge_cnt_q <= 6'd1;
                    end
                end
                S_ACTIVE: begin
                    // An edge coinciding with the idle terminal count opens the
                    // next transfer rather than extending this one.
                    if (idle_done) begin
                        state_q <= S_CHECK;
                        pend_q  <= fall;
                    end else if (fall && edge_cnt_q != 6'd63) begin
                        edge_cnt_q <= edge_cnt_q + 6'd1;
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        x_q     <= x_d;
                        y_q     <= y_d;
                        left_q  <= bus.Status_in[0];
                        right_q <= bus.Status_in[1];
                        mid_q   <= bus.Status_in[2];
                        valid_q <= 1'b1;
                        pend_q  <= pend_q | fall;
                        state_q <= S_APPLY;
                    end else begin
                        err_q      <= 1'b1;
                        idle_cnt_q <= 14'd0;
                        pend_q     <= 1'b0;
                        edge_cnt_q <= (fall || pend_q) ? 6'd1 : 6'd0;
                        state_q    <= (fall || pend_q) ? S_ACTIVE : S_IDLE;
                    end
                end
                S_APPLY: begin
                    idle_cnt_q <= 14'd0;
                    pend_q     <= 1'b0;
                    edge_cnt_q <= (fall || pend_q) ? 6'd1 : 6'd0;
                    state_q    <= (fall || pend_q) ? S_ACTIVE : S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.X_Position     = x_q;
    assign bus.Y_Position     = y_q;
    assign bus.Left_button    = left_q;
    assign bus.Right_button   = right_q;
    assign bus.Middle_button  = mid_q;
    assign bus.Position_valid = valid_q;
    assign bus.Packet_error   = err_q;

endmodule

// File: tb/tb_ps2_mouse_cursor.sv
module tb_ps2_mouse_cursor;
    localparam int IDLE = 64;
    localparam int HALF = 8;

    typedef struct {
        int         edges;
        logic [7:0] st;
        logic [7:0] xd;
        logic [7:0] yd;
        logic       pass;
    } vec_t;

    typedef struct {
        bit         ok;
        int         ex;
        int         ey;
        logic [2:0] btn;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pulse  = 0;
    exp_t sb[$];

    ps2_mouse_cursor_if bus();

    ps2_mouse_cursor #(.IDLE_CYCLES(IDLE)) dut (
        .Clock_100MHz(clk),
        .Clear_n     (rst_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Scoreboard: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && (bus.Position_valid || bus.Packet_error)) begin
            n_pulse++;
            if (sb.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind_valid", int'(bus.Position_valid), int'(e.ok));
                check("pulse_kind_error", int'(bus.Packet_error), int'(!e.ok));
                check("x_pos", int'(bus.X_Position), e.ex);
                check("y_pos", int'(bus.Y_Position), e.ey);
                check("buttons", int'({bus.Middle_button, bus.Right_button, bus.Left_button}),
                      int'(e.btn));
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_edges(input int n);
        for (int i = 0; i < n; i++) begin
            bus.PS2_CLK_in = 1'b0;
            tick(HALF);
            bus.PS2_CLK_in = 1'b1;
            tick(HALF);
        end
    endtask

    task automatic do_reset();
        bus.PS2_CLK_in = 1'b1;
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        sb.delete();
        tick(2);
    endtask

    task automatic send_packet(input vec_t v, input exp_t e);
        bus.Status_in           = v.st;
        bus.X_Direction         = v.xd;
        bus.Y_Direction         = v.yd;
        bus.Data_reporting_pass = v.pass;
        sb.push_back(e);
        send_edges(v.edges);
        for (int i = 0; i < 400 && sb.size() != 0; i++) tick(1);
        check("response_timeout", sb.size(), 0);
        sb.delete();
        tick(10);
    endtask

    function automatic int model_axis(input int cur, input int d, input int maxv);
        int r;
`ifdef PS2_MOUSE_ACCEL_EN
        if (d > 16 || d < -16) d = d * 2;
`endif
        r = cur + d;
        if (r < 0) r = 0;
        if (r > maxv) r = maxv;
        return r;
    endfunction

    function automatic vec_t mk(input int edges, input logic [7:0] st, input logic [7:0] xd,
                                input logic [7:0] yd, input logic pass);
        vec_t v;
        v.edges = edges; v.st = st; v.xd = xd; v.yd = yd; v.pass = pass;
        return v;
    endfunction

    function automatic exp_t ex(input bit ok, input int x, input int y, input logic [2:0] b);
        exp_t e;
        e.ok = ok; e.ex = x; e.ey = y; e.btn = b;
        return e;
    endfunction

    vec_t vecs[10];
    exp_t exps[10];

    initial begin
        int mx, my, dx, dy;
        logic [2:0] mb;
        bit ok;

        vecs[0] = mk(33, 8'h09, 8'h05, 8'h03, 1'b1);
        vecs[1] = mk(33, 8'h38, 8'hF6, 8'hFE, 1'b1);
        vecs[2] = mk(22, 8'h08, 8'h10, 8'h10, 1'b1);
        vecs[3] = mk(33, 8'h01, 8'h05, 8'h05, 1'b1);
        vecs[4] = mk(33, 8'h08, 8'h05, 8'h05, 1'b0);
        vecs[5] = mk(33, 8'h48, 8'h20, 8'h02, 1'b1);
        vecs[6] = mk(33, 8'h88, 8'h03, 8'h40, 1'b1);
        vecs[7] = mk(33, 8'h0E, 8'h00, 8'h00, 1'b1);
        vecs[8] = mk(34, 8'h08, 8'h07, 8'h07, 1'b1);
        vecs[9] = mk(32, 8'h08, 8'h07, 8'h07, 1'b1);
        mx = 320; my = 240; mb = 3'b000;
        foreach (vecs[i]) begin
            ok = (vecs[i].edges == 33) && vecs[i].pass && vecs[i].st[3];
            if (ok) begin
                dx = vecs[i].st[6] ? 0 : int'(vecs[i].xd) - (vecs[i].st[4] ? 256 : 0);
                dy = vecs[i].st[7] ? 0 : int'(vecs[i].yd) - (vecs[i].st[5] ? 256 : 0);
                mx = model_axis(mx, dx, 639);
                my = model_axis(my, -dy, 479);
                mb = vecs[i].st[2:0];
            end
            exps[i] = ex(ok, mx, my, mb);
        end

        bus.PS2_CLK_in = 1'b1;
        bus.Data_reporting_pass = 1'b0;
        bus.Status_in = 8'h00;
        bus.X_Direction = 8'h00;
        bus.Y_Direction = 8'h00;
        tick(3);
        rst_n = 1'b1;
        tick(5);
        check("reset_x", int'(bus.X_Position), 320);
        check("reset_y", int'(bus.Y_Position), 240);
        check("reset_buttons", int'({bus.Middle_button, bus.Right_button, bus.Left_button}), 0);
        check("reset_valid", int'(bus.Position_valid), 0);
        check("reset_error", int'(bus.Packet_error), 0);

        // Reset in the middle of a transfer: no pulse afterwards.
        bus.Status_in = 8'h09; bus.X_Direction = 8'h05; bus.Y_Direction = 8'h03;
        bus.Data_reporting_pass = 1'b1;
        n_pulse = 0;
        send_edges(10);
        do_reset();
        tick(200);
        check("midreset_pulses", n_pulse, 0);
        check("midreset_x", int'(bus.X_Position), 320);
        check("midreset_y", int'(bus.Y_Position), 240);
        check("midreset_buttons", int'({bus.Middle_button, bus.Right_button, bus.Left_button}), 0);

        // Hand-written corner sequences with literal expectations.
        n_pulse = 0;
        send_packet(mk(33, 8'h09, 8'h05, 8'h03, 1'b1), ex(1, 325, 237, 3'b001));
        check("single_valid_pulse", n_pulse, 1);
        do_reset();
        send_packet(mk(33, 8'h38, 8'hF6, 8'hFE, 1'b1), ex(1, 310, 242, 3'b000));

        do_reset();
`ifdef PS2_MOUSE_ACCEL_EN
        send_packet(mk(33, 8'h08, 8'hFF, 8'h00, 1'b1), ex(1, 639, 240, 3'b000));
        send_packet(mk(33, 8'h08, 8'h3C, 8'h00, 1'b1), ex(1, 639, 240, 3'b000));
        send_packet(mk(33, 8'h08, 8'h0A, 8'h00, 1'b1), ex(1, 639, 240, 3'b000));
        send_packet(mk(33, 8'h08, 8'h00, 8'hEE, 1'b1), ex(1, 639, 0, 3'b000));
`else
        send_packet(mk(33, 8'h08, 8'hFF, 8'h00, 1'b1), ex(1, 575, 240, 3'b000));
        send_packet(mk(33, 8'h08, 8'h3C, 8'h00, 1'b1), ex(1, 635, 240, 3'b000));
        send_packet(mk(33, 8'h08, 8'h0A, 8'h00, 1'b1), ex(1, 639, 240, 3'b000));
        send_packet(mk(33, 8'h08, 8'h00, 8'hEE, 1'b1), ex(1, 639, 2, 3'b000));
`endif
        send_packet(mk(33, 8'h08, 8'h00, 8'h05, 1'b1), ex(1, 639, 0, 3'b000));

        do_reset();
`ifdef PS2_MOUSE_ACCEL_EN
        send_packet(mk(33, 8'h18, 8'h24, 8'h00, 1'b1), ex(1, 0, 240, 3'b000));
`else
        send_packet(mk(33, 8'h18, 8'h24, 8'h00, 1'b1), ex(1, 100, 240, 3'b000));
`endif
        send_packet(mk(33, 8'h18, 8'h00, 8'h00, 1'b1), ex(1, 0, 240, 3'b000));

        do_reset();
`ifdef PS2_MOUSE_ACCEL_EN
        send_packet(mk(33, 8'h08, 8'h14, 8'h00, 1'b1), ex(1, 360, 240, 3'b000));
`else
        send_packet(mk(33, 8'h08, 8'h14, 8'h00, 1'b1), ex(1, 340, 240, 3'b000));
`endif

        // Table-driven vectors, chained from the reset position.
        do_reset();
        foreach (vecs[i]) send_packet(vecs[i], exps[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/ps2_mouse_cursor.md
Name: ps2_mouse_cursor

Overview:
- Downstream of the PS/2 mouse receiver. Turns its 3-byte movement packets into a clamped screen cursor position and button states for the display/VGA logic.
- Decides when a packet is complete by watching the PS/2 clock line as a sampled data input. The receiver provides no valid strobe.
- Everything runs in the 100 MHz system domain.

Parameters:
- H_MAX, 639, maximum X position; X range 0..H_MAX.
- V_MAX, 479, maximum Y position; Y range 0..V_MAX.
- X_INIT, 320, X position after reset.
- Y_INIT, 240, Y position after reset.
- IDLE_CYCLES, 10000, consecutive high samples of the PS/2 clock that mark end of transfer (100 us).
- ACCEL_THRESH, 16, magnitude above which a delta is doubled; used only with ACCEL_EN.

Ports:
- Clock_100MHz  input  1  system clock; all logic on rising edge.
- Clear_n  input  1  reset; asynchronous, active-low.
- PS2_CLK_in  input  1  PS/2 clock line, sampled as data and never used as a clock.
- Data_reporting_pass  input  1  receiver got 0xFA acknowledge for data reporting.
- Status_in  input  8  packet byte 0: [0]L [1]R [2]M [3]always-1 [4]Xsign [5]Ysign [6]Xovf [7]Yovf.
- X_Direction  input  8  packet byte 1, X delta low bits.
- Y_Direction  input  8  packet byte 2, Y delta low bits.
- X_Position  output  10  cursor X.
- Y_Position  output  10  cursor Y; 0 is the top of the screen.
- Left_button  output  1  status bit 0 of the last accepted packet.
- Right_button  output  1  status bit 1 of the last accepted packet.
- Middle_button  output  1  status bit 2 of the last accepted packet.
- Position_valid  output  1  one-cycle pulse when outputs update.
- Packet_error  output  1  one-cycle pulse when a transfer is rejected.

Behaviour:
- Reset values: X_Position=X_INIT, Y_Position=Y_INIT, all buttons 0, Position_valid=0, Packet_error=0. Internal: FSM=S_IDLE, all counters 0, synchronizer flops 1.
- Reset mid-operation aborts any transfer immediately, with no pulse.
- Synchronizer: PS2_CLK_in passes through 2 flops, then a third flop for edge detect. A falling edge is prev=1 and cur=0.
- Edge counter: 6 bits. Increments on each falling edge and saturates at 63.
- Idle counter: 14 bits. Cleared whenever the synced clock is 0. Increments while it is 1. Saturates at IDLE_CYCLES.
- FSM states:
  - S_IDLE: a falling edge moves to S_ACTIVE with edge count=1.
  - S_ACTIVE: count edges. When idle counter reaches IDLE_CYCLES, go to S_CHECK.
  - S_CHECK: exactly one cycle. Packet is accepted when edge count==33, Data_reporting_pass==1 and Status_in[3]==1. Accepted goes to S_APPLY. Otherwise pulse Packet_error and go to S_IDLE.
  - S_APPLY: exactly one cycle. Register new position and buttons, pulse Position_valid, clear counters, go to S_IDLE.
  - Packet_error also clears the counters.
- Latency: outputs change 2 cycles after the idle counter reaches IDLE_CYCLES.
- Receiver outputs are quasi-static at check time because the PS/2 clock has been idle for IDLE_CYCLES. No extra synchronization is applied to them.
- Host-inhibit pulses and command frames give edge counts other than 33 and are rejected with Packet_error. This is expected during initialization.
- Deltas:
  - dx={Status_in[4],X_Direction} and dy={Status_in[5],Y_Direction}, 9-bit two's complement, range -256..+255.
  - If Status_in[6] is set, dx is forced to 0. If Status_in[7] is set, dy is forced to 0. Overflow on one axis does not affect the other.
- Arithmetic: 12-bit signed.
  - X: newX = X_Position + dx.
  - Y: newY = Y_Position - dy; mouse up is positive, screen down is positive.
  - Clamp each result: below 0 gives 0; above H_MAX (X) or V_MAX (Y) gives the maximum. No wrap-around.
- A falling edge seen in S_CHECK or S_APPLY is counted toward the next transfer. The FSM enters S_ACTIVE with count=1.

Optional Feature:
- Macro: PS2_MOUSE_ACCEL_EN.
- Defined: a delta whose magnitude exceeds ACCEL_THRESH is doubled (shift left by 1) before clamping. Overflow forcing is applied first.
- Not defined: deltas are used 1:1, and ACCEL_THRESH is unused.

Test Plan:
- Reset: assert Clear_n=0 mid-transfer, then release -> X=320, Y=240, buttons 0, no Position_valid and no Packet_error pulse.
- Positive move: 33 edges, status=0x09, X=0x05, Y=0x03, pass=1, then 10000 idle cycles -> exactly one Position_valid pulse; X=325, Y=237, Left=1.
- Negative move: status=0x38, X=0xF6, Y=0xFE -> X=310, Y=242, buttons 0.
- Clamp:
  - From X=635 with dx=+10 -> X=639.
  - From Y=2 with dy=+5 -> Y=0.
  - dx=-256 at X=100 -> X=0.
- Rejects:
  - 22 edges then idle -> Packet_error pulse, positions unchanged.
  - 33 edges with status=0x01 (bit3=0) -> Packet_error pulse, positions unchanged.
  - 33 edges with pass=0 -> Packet_error pulse, positions unchanged.
- Overflow and accel:
  - status=0x48, X=0x20, Y=0x02 -> X unchanged, Y-=2.
  - With PS2_MOUSE_ACCEL_EN, X=0x14, status=0x08 -> X+=40; without the macro -> X+=20.
